// File: rtl/vmarb.sv
// Video-memory arbiter: shares one single-port synchronous RAM between the VGA
// scan-out fetcher (priority) and the CPU path, with a bounded video streak.
module vmarb #(
    parameter int MAX_VID_STREAK = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        vid_req,
    input  logic [16:0] vid_addr,
    output logic        vid_ack,
    output logic [7:0]  vid_data,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [16:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic [16:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_wren,
    input  logic [7:0]  mem_q,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    // Handshake: a requester raises req with stable address/data and holds it
    // until it sees a one-cycle ack; a req still high back in IDLE is a new access.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        READ  = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_VID_STREAK);

    state_t     state;
    state_t     state_next;
    logic [3:0] streak;
    logic       owner_cpu;
    logic       cpu_read;
    logic       grant_vid;
    logic       grant_cpu;

    assign state_dbg = state;

    always_comb begin
        grant_vid  = 1'b0;
        grant_cpu  = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                // Video wins unless the CPU has waited through a full streak.
                grant_vid = vid_req && !(cpu_req && (streak == STREAK_MAX));
                grant_cpu = cpu_req && !grant_vid;
                if (grant_vid || grant_cpu) state_next = ISSUE;
            end
            ISSUE:   state_next = READ;
            READ:    state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            mem_addr  <= 17'd0;
            mem_wdata <= 8'd0;
            mem_wren  <= 1'b0;
            vid_ack   <= 1'b0;
            cpu_ack   <= 1'b0;
            vid_data  <= 8'd0;
            cpu_rdata <= 8'd0;
            streak    <= 4'd0;
            owner_cpu <= 1'b0;
            cpu_read  <= 1'b0;
        end else begin
            state   <= state_next;
            busy    <= (state_next != IDLE);
            vid_ack <= 1'b0;
            cpu_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_vid) begin
                        mem_addr  <= vid_addr;
                        mem_wren  <= 1'b0;
                        owner_cpu <= 1'b0;
                        streak    <= cpu_req ? streak + 4'd1 : 4'd0;
                    end else if (grant_cpu) begin
                        mem_addr  <= cpu_addr;
                        mem_wren  <= cpu_we;
                        mem_wdata <= cpu_wdata;
                        owner_cpu <= 1'b1;
                        cpu_read  <= !cpu_we;
                        streak    <= 4'd0;
                    end
                end
                ISSUE: mem_wren <= 1'b0;
                READ: begin
                    // mem_q now carries the word addressed during ISSUE.
                    if (owner_cpu) begin
                        cpu_ack <= 1'b1;
                        if (cpu_read) cpu_rdata <= mem_q;
                    end else begin
                        vid_ack  <= 1'b1;
                        vid_data <= mem_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/vmarb.md
# vmarb

Video-memory arbiter for the 128 KB graphics frame buffer. It shares one single-port synchronous RAM (1-cycle read latency) between two requesters. The first is the VGA scan-out fetcher, which only reads and has priority. The second is the CPU-side memory controller path, which reads and writes. A bounded-streak rule keeps the CPU from starving.

## Interface
Parameters:
- MAX_VID_STREAK, default 4: number of consecutive video grants allowed while a CPU request is waiting before the CPU is forced in. Legal range is 1..15.

Ports:
- clock  in  1  system clock. All requesters and the RAM are in this domain.
- reset_n  in  1  synchronous, active-low reset.
- vid_req  in  1  video read request. Held high until vid_ack.
- vid_addr  in  17  video byte address. Stable while vid_req is high.
- vid_ack  out  1  one-cycle pulse: vid_data is valid.
- vid_data  out  8  video read data, registered.
- cpu_req  in  1  CPU request. Held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read. Stable while cpu_req is high.
- cpu_addr  in  17  CPU byte address.
- cpu_wdata  in  8  CPU write data.
- cpu_ack  out  1  one-cycle pulse: access complete, and cpu_rdata is valid if the access was a read.
- cpu_rdata  out  8  CPU read data, registered.
- mem_addr  out  17  RAM address, registered.
- mem_wdata  out  8  RAM write data, registered.
- mem_wren  out  1  RAM write enable, registered.
- mem_q  in  8  RAM read data. Valid the cycle after the address edge.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, READ, ACK.
- Reset values (reset_n low at a rising edge):
  - state = IDLE.
  - mem_addr = 0, mem_wdata = 0, mem_wren = 0.
  - vid_ack = 0, cpu_ack = 0.
  - vid_data = 0, cpu_rdata = 0.
  - streak = 0, busy = 0.
- IDLE, grant decision at the edge:
  - If vid_req is high and NOT (cpu_req high and streak == MAX_VID_STREAK): grant video.
  - Else if cpu_req is high: grant CPU.
  - Else stay in IDLE.
- On grant:
  - mem_addr is loaded from the winner's address.
  - mem_wren = cpu_we for a CPU grant, 0 for a video grant.
  - mem_wdata = cpu_wdata for a CPU grant; otherwise it holds its value.
  - The owner bit is recorded.
  - Next state is ISSUE.
- streak, a 4-bit counter, updates only on grants:
  - Video grant with cpu_req high: streak + 1.
  - Video grant with cpu_req low: 0.
  - CPU grant: 0.
- ISSUE: the RAM samples mem_addr/mem_wren at the closing edge. At that edge mem_wren is cleared to 0 and the state goes to READ.
- READ: at the closing edge:
  - If the owner is video: vid_data ← mem_q and vid_ack ← 1.
  - If the owner is CPU: cpu_ack ← 1, and cpu_rdata ← mem_q only if the access was a read. A CPU write leaves cpu_rdata unchanged.
  - Next state is ACK.
- ACK: the ack is high for exactly this cycle. At the closing edge the ack is cleared and the state returns to IDLE. Requests are not sampled in ACK.
- Requester rule: a requester that sees ack high at an edge deasserts req at that edge, or presents a new request. A req still high in IDLE afterwards is a new access.
- mem_addr holds its last value in all non-grant states.

## Timing
- Edge E0 is the edge at which IDLE samples the request.
  - ISSUE occupies the cycle after E0, and the RAM access happens at E1.
  - At E2, vid_data or cpu_rdata is registered and the ack rises.
  - At E3 the ack falls and the state returns to IDLE.
  - At E4 the next request is sampled.
- Request-to-ack latency is 3 edges. Throughput is one access per 4 cycles.
- Video and CPU requests high at the same E0: video wins unless streak == MAX_VID_STREAK.
- Worst-case CPU wait is MAX_VID_STREAK video accesses (4 cycles each) plus the access in flight.
- Reset mid-operation:
  - If reset arrives at E1 of a CPU write, the write still lands in the RAM because mem_wren is high at E1. No ack is produced.
  - If reset arrives in READ or ACK, the ack is suppressed or cleared, and the data registers go to 0.
- busy = (state != IDLE), registered with the state.

## Test plan
- Reset, then a lone video read of 0x1_2345 with RAM holding 0xA5: vid_ack high only in the 3rd cycle after the sampling edge, vid_data = 0xA5, and mem_wren stays 0 throughout.
- CPU write of 0x3C to 0x0_0010, then a CPU read of the same address: mem_wren is high for exactly one cycle (ISSUE), and the read returns cpu_rdata = 0x3C. cpu_rdata is unchanged across the write.
- vid_req and cpu_req both held continuously, MAX_VID_STREAK = 4: grant order is V,V,V,V,C,V,V,V,V,C. streak returns to 0 after each CPU grant.
- Video request and CPU request arrive at the same E0 with streak = 0: video is granted first, and cpu_ack arrives exactly 4 cycles after vid_ack.
- reset_n low at E1 of a CPU write of 0x77: the RAM location reads back 0x77 after reset, no cpu_ack is produced, and all outputs match the reset values the cycle after.
- Requester keeps req high for one extra cycle after ack: no extra access starts before E4, and that held req is treated as a new access.
